// File: rtl/sram_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_ctrl
// Purpose  : Sequencer for an 8-bit asynchronous SRAM. It sits behind the
//            AVR serial shift register: it takes the assembled address plus
//            single-cycle read/write requests and runs a fixed
//            SETUP / ACCESS / HOLD cycle on the SRAM bus. Read data comes back
//            with a one-cycle done pulse.
// Ports    : avr_clk, reset             - clock, synchronous active-high reset
//            addr_in, addr_valid        - address load from the shift register
//            req_rd, req_wr, wr_data    - access requests (pulses) and write byte
//            rd_data, done, busy        - read result, completion pulse, status
//            sram_addr, sram_data_out,
//            sram_data_oe, sram_data_in,
//            sram_ce_n, sram_oe_n,
//            sram_we_n                  - SRAM bus (tristate is at the top level)
// Options  : SRAM_AUTO_INC_EN - when defined, the address register increments
//            (modulo 2^ADDR_WIDTH) as each access completes, so block
//            transfers need no new address.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_ctrl #(
    parameter int ADDR_WIDTH    = 21,
    parameter int ACCESS_CYCLES = 2     // strobe low time, 1..15
) (
    input  logic                  avr_clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  addr_valid,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [7:0]            wr_data,
    output logic [7:0]            rd_data,
    output logic                  done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [7:0]            sram_data_out,
    output logic                  sram_data_oe,
    input  logic [7:0]            sram_data_in,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam logic [3:0] c_access_cycles = ACCESS_CYCLES[3:0];
`ifdef SRAM_AUTO_INC_EN
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;      // remaining ACCESS cycles
    logic       r_is_rd;    // current access is a read

    // sram_addr doubles as the address register: it only changes while
    // ce_n is high (IDLE) or on the same edge that raises ce_n.
    always_ff @(posedge avr_clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_is_rd       <= 1'b0;
            rd_data       <= 8'h00;
            done          <= 1'b0;
            busy          <= 1'b0;
            sram_addr     <= '0;
            sram_data_out <= 8'h00;
            sram_data_oe  <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (addr_valid) begin
                        sram_addr <= addr_in;
                    end
                    if (req_rd || req_wr) begin
                        r_state   <= ST_SETUP;
                        busy      <= 1'b1;
                        sram_ce_n <= 1'b0;
                        r_cnt     <= c_access_cycles;
                        // A simultaneous read and write resolves to the read.
                        r_is_rd   <= req_rd;
                        if (req_rd) begin
                            sram_oe_n    <= 1'b0;
                            sram_data_oe <= 1'b0;
                        end else begin
                            sram_data_out <= wr_data;
                            sram_data_oe  <= 1'b1;
                        end
                    end
                end

                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    // Read strobe is already low from SETUP; write strobe
                    // waits one cycle so address and data settle first.
                    if (!r_is_rd) begin
                        sram_we_n <= 1'b0;
                    end
                end

                ST_ACCESS: begin
                    if (r_cnt <= 4'd1) begin
                        r_state   <= ST_HOLD;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        done      <= 1'b1;
                        if (r_is_rd) begin
                            rd_data <= sram_data_in;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_HOLD: begin
                    r_state      <= ST_IDLE;
                    sram_ce_n    <= 1'b1;
                    sram_data_oe <= 1'b0;
                    busy         <= 1'b0;
`ifdef SRAM_AUTO_INC_EN
                    sram_addr    <= sram_addr + c_addr_one;
`endif
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_ctrl
// Purpose  : Directed self-checking bench for sram_bus_ctrl (ADDR_WIDTH=21,
//            ACCESS_CYCLES=2). Honors SRAM_AUTO_INC_EN in its expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_ctrl;

    logic        avr_clk = 1'b0;
    logic        reset;
    logic [20:0] addr_in;
    logic        addr_valid;
    logic        req_rd;
    logic        req_wr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        done;
    logic        busy;
    logic [20:0] sram_addr;
    logic [7:0]  sram_data_out;
    logic        sram_data_oe;
    logic [7:0]  sram_data_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SRAM_AUTO_INC_EN
    localparam bit c_inc = 1'b1;
`else
    localparam bit c_inc = 1'b0;
`endif

    always #5 avr_clk = ~avr_clk;

    // SRAM model: 0x012345 holds 0x5A, every other location reads addr^0xC3.
    assign sram_data_in = (sram_addr == 21'h012345) ? 8'h5A : (sram_addr[7:0] ^ 8'hC3);

    sram_bus_ctrl #(
        .ADDR_WIDTH    (21),
        .ACCESS_CYCLES (2)
    ) dut (
        .avr_clk       (avr_clk),
        .reset         (reset),
        .addr_in       (addr_in),
        .addr_valid    (addr_valid),
        .req_rd        (req_rd),
        .req_wr        (req_wr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .done          (done),
        .busy          (busy),
        .sram_addr     (sram_addr),
        .sram_data_out (sram_data_out),
        .sram_data_oe  (sram_data_oe),
        .sram_data_in  (sram_data_in),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; drives one request cycle.
    task automatic pulse(input logic rd, input logic wr, input logic av,
                         input logic [20:0] a, input logic [7:0] d);
        req_rd = rd; req_wr = wr; addr_valid = av; addr_in = a; wr_data = d;
        @(negedge avr_clk);
        req_rd = 1'b0; req_wr = 1'b0; addr_valid = 1'b0;
    endtask

    // Per-access observations; cycle 1 is the SETUP cycle.
    int          m_we, m_oe, m_doe, m_done, m_done_cyc, m_busy_low, m_viol, m_chg, m_busy1;
    logic [20:0] m_addr;
    logic [7:0]  m_rd, m_dout;

    task automatic monitor(input bit inj);
        bit first = 1'b1;
        m_we = 0; m_oe = 0; m_doe = 0; m_done = 0; m_done_cyc = -1;
        m_busy_low = -1; m_viol = 0; m_chg = 0; m_busy1 = 0;
        m_addr = '0; m_rd = 8'h00; m_dout = 8'h00;
        for (int i = 1; i <= 12; i++) begin
            if (i == 1) m_busy1 = int'(busy);
            if (!sram_we_n) m_we++;
            if (!sram_oe_n) m_oe++;
            if (sram_data_oe) begin m_doe++; m_dout = sram_data_out; end
            if (!sram_we_n && !sram_oe_n) m_viol++;
            if (sram_data_oe && !sram_oe_n) m_viol++;
            if (!sram_ce_n) begin
                if (first) begin m_addr = sram_addr; first = 1'b0; end
                else if (sram_addr != m_addr) m_chg++;
            end
            if (done) begin
                m_done++;
                if (m_done_cyc < 0) m_done_cyc = i;
                m_rd = rd_data;
            end
            if (!busy && m_busy_low < 0) m_busy_low = i;
            if (inj && i == 2) begin
                req_wr = 1'b1; addr_valid = 1'b1; addr_in = 21'h000020; wr_data = 8'hFF;
            end else begin
                req_wr = 1'b0; addr_valid = 1'b0;
            end
            @(negedge avr_clk);
        end
    endtask

    initial begin
        reset = 1'b1; addr_in = '0; addr_valid = 1'b0;
        req_rd = 1'b0; req_wr = 1'b0; wr_data = 8'h00;
        repeat (3) @(negedge avr_clk);
        check("rst_ce_n",  sram_ce_n, 1);
        check("rst_oe_n",  sram_oe_n, 1);
        check("rst_we_n",  sram_we_n, 1);
        check("rst_doe",   sram_data_oe, 0);
        check("rst_addr",  sram_addr, 0);
        check("rst_dout",  sram_data_out, 0);
        check("rst_rd",    rd_data, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        reset = 1'b0;
        @(negedge avr_clk);

        // 1: write 0xA5 at 0x012345
        pulse(1'b0, 1'b0, 1'b1, 21'h012345, 8'h00);
        pulse(1'b0, 1'b1, 1'b0, 21'h000000, 8'hA5);
        monitor(1'b0);
        check("wr_addr",     m_addr, 21'h012345);
        check("wr_we_cnt",   m_we, 2);
        check("wr_oe_cnt",   m_oe, 0);
        check("wr_doe_cnt",  m_doe, 4);
        check("wr_dout",     m_dout, 8'hA5);
        check("wr_done_cnt", m_done, 1);
        check("wr_done_cyc", m_done_cyc, 4);
        check("wr_busy_set", m_busy1, 1);
        check("wr_busy_low", m_busy_low, 5);
        check("wr_viol",     m_viol, 0);
        check("wr_addr_chg", m_chg, 0);

        // 2: read from 0x012345, model returns 0x5A
        pulse(1'b1, 1'b0, 1'b1, 21'h012345, 8'h00);
        monitor(1'b0);
        check("rd_addr",     m_addr, 21'h012345);
        check("rd_oe_cnt",   m_oe, 3);
        check("rd_we_cnt",   m_we, 0);
        check("rd_doe_cnt",  m_doe, 0);
        check("rd_data_at_done", m_rd, 8'h5A);
        check("rd_done_cyc", m_done_cyc, 4);
        check("rd_data_held", rd_data, 8'h5A);

        // 3: same-cycle address + read, then requests while busy are ignored
        pulse(1'b1, 1'b0, 1'b1, 21'h000010, 8'h00);
        monitor(1'b1);
        check("ign_addr",     m_addr, 21'h000010);
        check("ign_done_cnt", m_done, 1);
        check("ign_we_cnt",   m_we, 0);
        check("ign_rd",       m_rd, 8'hD3);
        check("ign_addr_end", sram_addr, c_inc ? 21'h000011 : 21'h000010);
        check("ign_busy_end", busy, 0);

        // 4: read and write together -> read only
        pulse(1'b1, 1'b1, 1'b1, 21'h000040, 8'h77);
        monitor(1'b0);
        check("rw_we_cnt",   m_we, 0);
        check("rw_oe_cnt",   m_oe, 3);
        check("rw_doe_cnt",  m_doe, 0);
        check("rw_rd",       m_rd, 8'h83);
        check("rw_done_cnt", m_done, 1);

        // 5: reset during ACCESS of a write
        pulse(1'b0, 1'b1, 1'b1, 21'h000100, 8'h3C);
        @(negedge avr_clk);             // now in first ACCESS cycle
        check("mid_we_low", sram_we_n, 0);
        reset = 1'b1;
        @(negedge avr_clk);
        check("mid_rst_we_n", sram_we_n, 1);
        check("mid_rst_ce_n", sram_ce_n, 1);
        check("mid_rst_doe",  sram_data_oe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_addr", sram_addr, 0);
        reset = 1'b0;
        monitor(1'b0);
        check("mid_rst_no_done", m_done, 0);
        check("mid_rst_no_we",   m_we, 0);

        // 6: address wrap with auto-increment (or no change without it)
        pulse(1'b0, 1'b0, 1'b1, 21'h1FFFFF, 8'h00);
        pulse(1'b0, 1'b1, 1'b0, 21'h000000, 8'h11);
        monitor(1'b0);
        check("inc_first_addr", m_addr, 21'h1FFFFF);
        pulse(1'b0, 1'b1, 1'b0, 21'h000000, 8'h22);
        monitor(1'b0);
        check("inc_second_addr", m_addr, c_inc ? 21'h000000 : 21'h1FFFFF);
        check("inc_second_dout", m_dout, 8'h22);
        check("inc_final_addr",  sram_addr, c_inc ? 21'h000001 : 21'h1FFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
SRAM bus sequencer directly downstream of the AVR serial shift register (sreg) in the CPLD.
- Consumes the 21-bit address assembled by the shift register, plus AVR read/write requests.
- Drives the 8-bit async SRAM bus (addr, data, ce_n, oe_n, we_n) with fixed timing.
- Returns read data with a done pulse.
- Optional address auto-increment enables AVR block transfers without re-shifting the address.

Parameters:
ADDR_WIDTH, 21, SRAM address width; matches sram_addr.
ACCESS_CYCLES, 2, avr_clk cycles strobe (oe_n/we_n) held low; legal range 1..15.

Ports:
avr_clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
addr_in  in  ADDR_WIDTH  address from upstream shift register
addr_valid  in  1  one-cycle pulse; addr_in valid
req_rd  in  1  one-cycle read request pulse
req_wr  in  1  one-cycle write request pulse
wr_data  in  8  write byte; sampled with req_wr
rd_data  out  8  last byte read from SRAM
done  out  1  one-cycle pulse, access complete
busy  out  1  high while an access is in progress
sram_addr  out  ADDR_WIDTH  SRAM address
sram_data_out  out  8  SRAM write data
sram_data_oe  out  1  1 = drive sram_data (top level tristates)
sram_data_in  in  8  SRAM data bus read-back
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low

Behaviour:
- Reset values (next edge with reset=1, including mid-access):
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_data_oe=0
  - sram_addr=0, sram_data_out=0, rd_data=0, busy=0, done=0
  - FSM returns to IDLE; an in-flight access is abandoned with no done pulse.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - addr_valid=1 loads addr_in into the address register.
  - req_rd or req_wr moves to SETUP and sets busy=1.
  - If addr_valid and a request arrive in the same cycle, the new address is used for that access.
  - If req_rd and req_wr arrive together, the read wins and the write is dropped.
  - A write latches wr_data.
- SETUP, 1 cycle:
  - ce_n=0; sram_addr stable.
  - Write: data_oe=1, data_out=wr_data, we_n=1.
  - Read: data_oe=0, oe_n=0.
- ACCESS, ACCESS_CYCLES cycles, counted by a 4-bit down-counter:
  - Write: we_n=0.
  - Read: oe_n=0; rd_data captures sram_data_in on the edge ending the last ACCESS cycle.
- HOLD, 1 cycle:
  - we_n=1 and oe_n=1; ce_n=0.
  - Write: data still driven (data_oe=1) for hold time.
  - done=1 for this cycle only.
- Exit HOLD to IDLE:
  - ce_n=1, data_oe=0, busy=0.
  - Optional address increment applied on this edge.
- Latency: request sampled at edge k gives SETUP in cycle k+1, done in cycle k+2+ACCESS_CYCLES, idle again at k+3+ACCESS_CYCLES. Back-to-back requests are accepted in that idle cycle.
- Ignored while busy=1:
  - req_rd, req_wr, addr_valid — no queuing; the AVR firmware must poll busy or wait for done.
- Invariants:
  - we_n and oe_n are never low simultaneously.
  - data_oe is never 1 during a read.
  - sram_addr never changes while ce_n=0.

Optional Feature:
SRAM_AUTO_INC_EN
- Defined:
  - On the HOLD→IDLE edge the address register increments by 1, modulo 2^ADDR_WIDTH (0x1FFFFF wraps to 0x000000).
  - If addr_valid coincides with that edge it cannot be accepted (busy=1), so no conflict arises.
- Undefined: the address changes only via addr_valid or reset.

Test Plan:
1. Reset, then addr_valid with addr_in=0x012345, then req_wr with wr_data=0xA5 → sram_addr=0x012345; we_n low for exactly 2 cycles; data_oe=1 from SETUP through HOLD; done in cycle k+4; busy drops the cycle after.
2. With the model SRAM at 0x012345 returning 0x5A, req_rd → oe_n low for 3 cycles (SETUP plus 2 ACCESS); rd_data=0x5A when done=1; we_n stays 1; data_oe stays 0.
3. Same-cycle addr_valid=0x000010 and req_rd, then req_wr and addr_valid=0x000020 issued while busy → read uses 0x000010; only one done pulse; address stays 0x000010.
4. req_rd and req_wr in the same cycle → only a read occurs; we_n never low.
5. Assert reset during ACCESS of a write → next edge: we_n=1, ce_n=1, data_oe=0, busy=0, no done pulse.
6. SRAM_AUTO_INC_EN defined: load 0x1FFFFF, then two writes → first access at 0x1FFFFF, second at 0x000000. Without the macro → both accesses at 0x1FFFFF.
